gptim_multi: RTL and testbench

- Parametrised general-purpose timer. Successor to the fixed single-channel TIM0/TIM1 timers.
- Provides one up-counter with a programmable prescaler and reload (TOP) value.
- Adds NUM_CHANNELS compare channels, each with a PWM output, plus a one-shot mode.
- Sits on the core peripheral register bus at the TIMx base address and drives one interrupt line into the implementation-specific trap range (TRAP_CODE_TIM0/TIM1).

---
 rtl/gptim_multi_pkg.sv | 30 +++
 rtl/gptim_prescaler.sv | 39 +++
 rtl/gptim_multi.sv | 184 ++++++++++++++++++
 tb/tb_gptim_multi.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gptim_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gptim_multi_pkg
// Brief    : Shared definitions for the multi-channel general-purpose timer.
// Revision : 1.0
// ============================================================================
package gptim_multi_pkg;

  localparam int GPTIM_MAX_CHANNELS = 8;

  localparam int GPTIM_OFS_CTRL     = 'h00;
  localparam int GPTIM_OFS_STATUS   = 'h04;
  localparam int GPTIM_OFS_PRESCALE = 'h08;
  localparam int GPTIM_OFS_COUNT    = 'h0C;
  localparam int GPTIM_OFS_TOP      = 'h10;
  localparam int GPTIM_OFS_CMP0     = 'h14;

  typedef struct packed {
    logic [GPTIM_MAX_CHANNELS-1:0] cmp_ie;
    logic                          ovf_ie;
    logic                          oneshot;
    logic                          en;
  } gptim_ctrl_t;

  function automatic logic [31:0] gptim_byte_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gptim_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : gptim_prescaler
// Brief    : Free-running 0..PRESCALE counter producing the timer tick.
// Revision : 1.0
// ============================================================================
module gptim_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      clear_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      tick_o
);

  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [PRESCALE_WIDTH-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
    if (!en_i || clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gptim_multi.sv
`default_nettype none
// ============================================================================
// Module   : gptim_multi
// Brief    : Prescaled up-counter with TOP reload, compare/PWM channels,
//            one-shot mode and a level interrupt, on a simple register bus.
// Revision : 1.0
// ============================================================================
module gptim_multi
  import gptim_multi_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 16,
  parameter int ADDR_WIDTH     = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    wr_en,
  input  logic [31:0]             wr_data,
  input  logic [3:0]              wr_strobe,
  input  logic                    rd_en,
  output logic [31:0]             rd_data,
  output logic                    rd_valid,
  output logic [NUM_CHANNELS-1:0] pwm_o,
  output logic                    irq
);

  localparam logic [GPTIM_MAX_CHANNELS-1:0] IE_MASK =
    GPTIM_MAX_CHANNELS'((1 << NUM_CHANNELS) - 1);

  gptim_ctrl_t               ctrl_q, ctrl_d;
  logic                      ovf_q, ovf_d;
  logic [NUM_CHANNELS-1:0]   cmpf_q, cmpf_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [COUNT_WIDTH-1:0]    top_q, top_d;
  logic                      irq_q;
  logic [31:0]               rd_data_q;
  logic                      rd_valid_q;

  int                        w_ofs;
  logic [31:0]               w_rd_word;
  logic [31:0]               w_mask;
  logic [31:0]               w_wr_word;
  logic [31:0]               w_w1c;
  logic                      w_wr_ctrl, w_wr_status, w_wr_presc, w_wr_count, w_wr_top;
  logic                      w_tick;
  logic                      w_evt;
  logic                      w_wrap;
  logic [COUNT_WIDTH-1:0]    w_count_next;
  logic [COUNT_WIDTH-1:0]    w_cmp [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   w_cmp_set;
  logic                      w_unused;

  assign w_ofs = int'({addr[ADDR_WIDTH-1:2], 2'b00});

  always_comb begin
    w_rd_word = '0;
    case (w_ofs)
      GPTIM_OFS_CTRL:     w_rd_word = {16'b0, ctrl_q.cmp_ie, ctrl_q.ovf_ie, 5'b0,
                                       ctrl_q.oneshot, ctrl_q.en};
      GPTIM_OFS_STATUS:   w_rd_word = {16'b0, 8'(cmpf_q), 7'b0, ovf_q};
      GPTIM_OFS_PRESCALE: w_rd_word = 32'(presc_q);
      GPTIM_OFS_COUNT:    w_rd_word = 32'(count_q);
      GPTIM_OFS_TOP:      w_rd_word = 32'(top_q);
      default:            w_rd_word = '0;
    endcase
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (w_ofs == GPTIM_OFS_CMP0 + 4 * i) begin
        w_rd_word = 32'(w_cmp[i]);
      end
    end
  end

  // Byte-merged write: the current register image with the strobed bytes replaced.
  assign w_mask      = gptim_byte_mask(wr_strobe);
  assign w_wr_word   = (w_rd_word & ~w_mask) | (wr_data & w_mask);
  assign w_w1c       = wr_data & w_mask;

  assign w_wr_ctrl   = wr_en && (w_ofs == GPTIM_OFS_CTRL);
  assign w_wr_status = wr_en && (w_ofs == GPTIM_OFS_STATUS);
  assign w_wr_presc  = wr_en && (w_ofs == GPTIM_OFS_PRESCALE);
  assign w_wr_count  = wr_en && (w_ofs == GPTIM_OFS_COUNT);
  assign w_wr_top    = wr_en && (w_ofs == GPTIM_OFS_TOP);

  gptim_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (ctrl_q.en),
    .clear_i    (w_wr_ctrl && !w_wr_word[0]),
    .prescale_i (presc_q),
    .tick_o     (w_tick)
  );

  assign w_wrap       = (count_q == top_q);
  assign w_count_next = w_wrap ? '0 : count_q + COUNT_WIDTH'(1);
  // A software COUNT write suppresses all tick-driven events in that cycle.
  assign w_evt        = w_tick && !w_wr_count;

  always_comb begin
    ctrl_d = ctrl_q;
    if (w_evt && w_wrap && ctrl_q.oneshot) begin
      ctrl_d.en = 1'b0;
    end
    if (w_wr_ctrl) begin
      ctrl_d.en      = w_wr_word[0];
      ctrl_d.oneshot = w_wr_word[1];
      ctrl_d.ovf_ie  = w_wr_word[7];
      ctrl_d.cmp_ie  = w_wr_word[15:8] & IE_MASK;
    end

    ovf_d  = (ovf_q && !(w_wr_status && w_w1c[0])) || (w_evt && w_wrap);
    cmpf_d = (cmpf_q & ~({NUM_CHANNELS{w_wr_status}} & w_w1c[8 +: NUM_CHANNELS]))
             | w_cmp_set;

    presc_d = w_wr_presc ? w_wr_word[PRESCALE_WIDTH-1:0] : presc_q;
    top_d   = w_wr_top   ? w_wr_word[COUNT_WIDTH-1:0]    : top_q;

    count_d = count_q;
    if (w_wr_count) begin
      count_d = w_wr_word[COUNT_WIDTH-1:0];
    end else if (w_tick) begin
      count_d = w_count_next;
    end
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    logic [COUNT_WIDTH-1:0] cmp_q, cmp_d;
    logic                   pwm_q, pwm_d;

    assign cmp_d = (wr_en && (w_ofs == GPTIM_OFS_CMP0 + 4 * gi))
                   ? w_wr_word[COUNT_WIDTH-1:0] : cmp_q;
    assign pwm_d = ctrl_q.en && (count_q < cmp_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cmp_q <= '0;
        pwm_q <= 1'b0;
      end else begin
        cmp_q <= cmp_d;
        pwm_q <= pwm_d;
      end
    end

    assign w_cmp[gi]     = cmp_q;
    assign w_cmp_set[gi] = w_evt && (w_count_next == cmp_q);
    assign pwm_o[gi]     = pwm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      cmpf_q     <= '0;
      presc_q    <= '0;
      count_q    <= '0;
      top_q      <= '1;
      irq_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      cmpf_q     <= cmpf_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      top_q      <= top_d;
      irq_q      <= |({cmpf_q, ovf_q} & {ctrl_q.cmp_ie[NUM_CHANNELS-1:0], ctrl_q.ovf_ie});
      rd_data_q  <= rd_en ? w_rd_word : '0;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

  assign w_unused = ^{addr[1:0], w_wr_word, w_w1c};

endmodule
`default_nettype wire

// File: tb/tb_gptim_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_gptim_multi
// Brief    : Directed self-checking bench for gptim_multi with a read scoreboard.
// Revision : 1.0
// ============================================================================
module tb_gptim_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_strobe;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  pwm_o;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  gptim_multi #(
    .NUM_CHANNELS   (4),
    .COUNT_WIDTH    (32),
    .PRESCALE_WIDTH (16),
    .ADDR_WIDTH     (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_strobe (wr_strobe),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .pwm_o     (pwm_o),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    addr = a; wr_data = d; wr_strobe = s; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string t);
    addr = a; rd_en = 1'b1;
    exp_q.push_back(e); tag_q.push_back(t);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic rw(input logic [5:0] a, input logic [31:0] d, input logic [31:0] e, input string t);
    addr = a; wr_data = d; wr_strobe = 4'hF; wr_en = 1'b1; rd_en = 1'b1;
    exp_q.push_back(e); tag_q.push_back(t);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: every rd_valid pulse retires the oldest expected read.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    string       t;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", 32'(rd_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, rd_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int ones0, ones1, ones2;

    addr = '0; wr_en = 1'b0; wr_data = '0; wr_strobe = '0; rd_en = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pwm",      32'(pwm_o),    32'h0);
    chk("rst_irq",      32'(irq),      32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_data",  rd_data,       32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(6'h10, 32'hFFFF_FFFF, "rst_top");
    rd(6'h0C, 32'h0,         "rst_count");
    rd(6'h00, 32'h0,         "rst_ctrl");
    rd(6'h04, 32'h0,         "rst_status");

    // Continuous overflow: 10 counts x 4 prescaled cycles
    wr(6'h08, 32'd3);
    wr(6'h10, 32'd9);
    wr(6'h00, 32'h81);
    n = 0;
    while (irq !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_irq_latency", 32'(n), 32'd41);
    rd(6'h04, 32'h0000_0F01, "ovf_status");
    rd(6'h0C, 32'h0,         "ovf_count_wrapped");
    wr(6'h04, 32'h1);
    idle(1);
    chk("ovf_w1c_irq_drop", 32'(irq), 32'h0);
    wr(6'h00, 32'h0);
    wr(6'h04, 32'hFFFF);

    // PWM
    wr(6'h0C, 32'd0);
    wr(6'h08, 32'd0);
    wr(6'h10, 32'd9);
    wr(6'h14, 32'd3);
    wr(6'h18, 32'd0);
    wr(6'h1C, 32'd12);
    wr(6'h20, 32'd0);
    wr(6'h00, 32'h1);
    ones0 = 0; ones1 = 0; ones2 = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      ones0 += int'(pwm_o[0]);
      ones1 += int'(pwm_o[1]);
      ones2 += int'(pwm_o[2]);
    end
    chk("pwm0_duty", 32'(ones0), 32'd9);
    chk("pwm1_zero", 32'(ones1), 32'd0);
    chk("pwm2_full", 32'(ones2), 32'd30);
    wr(6'h00, 32'h0);
    idle(1);
    chk("pwm_disabled", 32'(pwm_o), 32'h0);

    // One-shot
    wr(6'h0C, 32'd0);
    wr(6'h10, 32'd5);
    wr(6'h04, 32'hFFFF);
    wr(6'h00, 32'h3);
    idle(20);
    rd(6'h00, 32'h2,         "oneshot_en_cleared");
    rd(6'h0C, 32'h0,         "oneshot_count_zero");
    rd(6'h04, 32'h0000_0B01, "oneshot_status");
    wr(6'h04, 32'hFFFF);
    idle(10);
    rd(6'h04, 32'h0,         "oneshot_no_refire");
    rd(6'h0C, 32'h0,         "oneshot_count_held");

    // COUNT write colliding with a tick that would have matched CMP[0]
    wr(6'h14, 32'd1);
    wr(6'h10, 32'd9);
    wr(6'h0C, 32'd0);
    wr(6'h04, 32'hFFFF);
    wr(6'h00, 32'h1);
    wr(6'h0C, 32'd5);
    wr(6'h00, 32'h0);
    rd(6'h0C, 32'd6,         "coll_count_kept");
    rd(6'h04, 32'h0,         "coll_no_flag");

    // W1C of CMP[0] on the cycle it re-fires
    wr(6'h14, 32'd3);
    wr(6'h0C, 32'd0);
    wr(6'h04, 32'hFFFF);
    wr(6'h00, 32'h1);
    idle(12);
    wr(6'h04, 32'h100);
    wr(6'h00, 32'h0);
    rd(6'h04, 32'h0000_0B01, "coll_w1c_set_wins");
    wr(6'h04, 32'h100);
    rd(6'h04, 32'h0000_0A01, "w1c_clears");
    wr(6'h04, 32'hFFFF);

    // Bus behaviour
    wr(6'h18, 32'h1122_3344);
    wr(6'h18, 32'h0000_AB00, 4'b0010);
    rd(6'h18, 32'h1122_AB44, "byte_strobe");
    rw(6'h18, 32'h5566_7788, 32'h1122_AB44, "rw_returns_old");
    rd(6'h18, 32'h5566_7788, "rw_write_applied");
    wr(6'h08, 32'hFFFF_FFFF);
    rd(6'h08, 32'h0000_FFFF, "prescale_width");
    wr(6'h08, 32'h0);
    wr(6'h00, 32'hFFFF_FF7E);
    rd(6'h00, 32'h0000_0F02, "ctrl_field_mask");
    wr(6'h00, 32'h0);
    wr(6'h30, 32'hFFFF_FFFF);
    rd(6'h30, 32'h0, "unmapped_read");
    chk("rd_valid_pulse", 32'(rd_valid), 32'h1);
    @(negedge clk);
    chk("rd_valid_drop", 32'(rd_valid), 32'h0);

    // Reset mid-count with irq asserted
    wr(6'h10, 32'd9);
    wr(6'h14, 32'd3);
    wr(6'h0C, 32'd0);
    wr(6'h04, 32'hFFFF);
    wr(6'h00, 32'h181);
    idle(6);
    chk("pre_reset_irq", 32'(irq), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_irq",      32'(irq),      32'h0);
    chk("midrst_pwm",      32'(pwm_o),    32'h0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(6'h10, 32'hFFFF_FFFF, "midrst_top");
    rd(6'h0C, 32'h0,         "midrst_count");
    rd(6'h00, 32'h0,         "midrst_ctrl");
    rd(6'h14, 32'h0,         "midrst_cmp0");

    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
